// File: rtl/cnn_pkg.sv
// Shared constants for the CNN pipeline stages: DRAM region bases, packed
// feature-map address layout, and the max_pool one-hot state encoding.
package cnn_pkg;

  localparam int PARAM_BASE = 0;
  localparam int FMAP_BASE  = 131072;
  localparam int POOL_BASE  = 196608;
  localparam int NUM_PARAM  = 3;

  localparam int D_W     = 4;
  localparam int Y_W     = 5;
  localparam int X_W     = 5;
  localparam int PKT_AW  = 4 + D_W + Y_W + X_W;

  localparam int I_IDLE  = 0;
  localparam int I_LD    = 1;
  localparam int I_EVAL  = 2;
  localparam int I_FLUSH = 3;
  localparam int I_DONE  = 4;
  localparam int NST     = 5;

  localparam logic [NST-1:0] ST_IDLE  = NST'(1) << I_IDLE;
  localparam logic [NST-1:0] ST_LD    = NST'(1) << I_LD;
  localparam logic [NST-1:0] ST_EVAL  = NST'(1) << I_EVAL;
  localparam logic [NST-1:0] ST_FLUSH = NST'(1) << I_FLUSH;
  localparam logic [NST-1:0] ST_DONE  = NST'(1) << I_DONE;

  // Region base plus the packed {pad, d, y, x} offset shared by all layers.
  function automatic logic [PKT_AW-1:0] pack_addr(
    input int             base,
    input logic [D_W-1:0] d,
    input logic [Y_W-1:0] y,
    input logic [X_W-1:0] x
  );
    return PKT_AW'(base) + {4'd0, d, y, x};
  endfunction

endpackage

// File: rtl/max_pool_if.sv
// DRAM port bundle between max_pool (master) and the memory (slave).
interface max_pool_if #(
  parameter int DW = 32,
  parameter int AW = 18
);
  logic          dram_valid;
  logic [DW-1:0] data_in;
  logic [DW-1:0] data_out;
  logic [AW-1:0] addr_in;
  logic [AW-1:0] addr_out;
  logic          dram_en_rd;
  logic          dram_en_wr;

  modport master (
    input  dram_valid, data_in,
    output data_out, addr_in, addr_out, dram_en_rd, dram_en_wr
  );

  modport slave (
    output dram_valid, data_in,
    input  data_out, addr_in, addr_out, dram_en_rd, dram_en_wr
  );
endinterface

// File: rtl/pool_acc.sv
// Signed running max over the four quadrant reads of one output pixel;
// the final max is registered out one cycle after the q=3 datum.
module pool_acc #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  srst,
  input  logic                  i_vld,
  input  logic [1:0]            i_q,
  input  logic [DATA_WIDTH-1:0] i_dat,
  output logic                  o_vld,
  output logic [DATA_WIDTH-1:0] o_dat
);

  logic signed [DATA_WIDTH-1:0] r_acc;
  logic signed [DATA_WIDTH-1:0] w_max;
  logic                         r_vld;
  logic [DATA_WIDTH-1:0]        r_dat;

  always_comb begin
    w_max = r_acc;
    if (i_q == 2'd0 || $signed(i_dat) > r_acc) w_max = $signed(i_dat);
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      r_acc <= '0;
      r_vld <= 1'b0;
      r_dat <= '0;
    end else begin
      r_vld <= i_vld && (i_q == 2'd3);
      if (i_vld) r_acc <= w_max;
      if (i_vld && i_q == 2'd3) r_dat <= w_max;
    end
  end

  assign o_vld = r_vld;
  assign o_dat = r_dat;

endmodule

// File: rtl/max_pool.sv
// 2x2 stride-2 max-pool of a packed DRAM feature map, one layer per enable.
// One read per cycle in EVAL; each pooled write lands 5 cycles after its q=0 read.
module max_pool
  import cnn_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 18
) (
  input  logic       clk,
  input  logic       srst,
  input  logic       enable,
  output logic       done,
  max_pool_if.master dram
);

  logic [NST-1:0]        r_state, w_next;
  logic [1:0]            r_lp;
  logic                  r_fl;
  logic [5:0]            r_w, r_h, r_dn;
  logic [1:0]            r_q;
  logic [X_W-1:0]        r_ox;
  logic [Y_W-1:0]        r_oy;
  logic [5:0]            r_d;
  logic                  r_dvld;
  logic [1:0]            r_dq;
  logic [ADDR_WIDTH-1:0] r_wa, r_addr_out;

  logic [4:0]            w_ow, w_oh;
  logic                  w_empty, w_ox_last, w_oy_last, w_px_last, w_rd_last;
  logic [X_W-1:0]        w_x;
  logic [Y_W-1:0]        w_y;
  logic [ADDR_WIDTH-1:0] w_raddr, w_waddr;
  logic                  w_acc_vld;
  logic [DATA_WIDTH-1:0] w_acc_dat;
  logic                  w_unused;

  assign w_unused  = dram.dram_valid;
  assign w_ow      = r_w[5:1];
  assign w_oh      = r_h[5:1];
  // D is still on the read bus during the last LD_PARAM cycle.
  assign w_empty   = (w_ow == 5'd0) || (w_oh == 5'd0) || (dram.data_in[5:0] == 6'd0);
  assign w_ox_last = (r_ox == w_ow - 5'd1);
  assign w_oy_last = (r_oy == w_oh - 5'd1);
  assign w_px_last = w_ox_last && w_oy_last && (r_d == r_dn - 6'd1);
  assign w_rd_last = r_state[I_EVAL] && (r_q == 2'd3) && w_px_last;
  assign w_x       = {r_ox[X_W-2:0], r_q[0]};
  assign w_y       = {r_oy[Y_W-2:0], r_q[1]};
  assign w_raddr   = ADDR_WIDTH'(pack_addr(FMAP_BASE, r_d[D_W-1:0], w_y, w_x));
  assign w_waddr   = ADDR_WIDTH'(pack_addr(POOL_BASE, r_d[D_W-1:0], r_oy, r_ox));

  always_ff @(posedge clk) begin
    if (srst) r_state <= ST_IDLE;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    if (r_state[I_IDLE]) begin
      if (enable) w_next = ST_LD;
    end else if (r_state[I_LD]) begin
      if (r_lp == 2'(NUM_PARAM)) w_next = w_empty ? ST_DONE : ST_EVAL;
    end else if (r_state[I_EVAL]) begin
      if (w_rd_last) w_next = ST_FLUSH;
    end else if (r_state[I_FLUSH]) begin
      if (r_fl) w_next = ST_DONE;
    end else begin
      w_next = ST_IDLE;
    end
  end

  always_comb begin
    dram.dram_en_rd = 1'b0;
    dram.addr_in    = '0;
    done            = r_state[I_DONE];
    if (r_state[I_LD]) begin
      dram.dram_en_rd = 1'b1;
      if (r_lp < 2'(NUM_PARAM)) dram.addr_in = ADDR_WIDTH'(PARAM_BASE) + ADDR_WIDTH'(r_lp);
    end else if (r_state[I_EVAL]) begin
      dram.dram_en_rd = 1'b1;
      dram.addr_in    = w_raddr;
    end
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      r_lp       <= '0;
      r_fl       <= 1'b0;
      r_w        <= '0;
      r_h        <= '0;
      r_dn       <= '0;
      r_q        <= '0;
      r_ox       <= '0;
      r_oy       <= '0;
      r_d        <= '0;
      r_dvld     <= 1'b0;
      r_dq       <= '0;
      r_wa       <= '0;
      r_addr_out <= '0;
    end else begin
      if (r_state[I_IDLE]) begin
        r_lp <= '0;
        r_fl <= 1'b0;
        r_q  <= '0;
        r_ox <= '0;
        r_oy <= '0;
        r_d  <= '0;
      end
      // Word k arrives one cycle after address k, i.e. at r_lp == k+1.
      if (r_state[I_LD]) begin
        r_lp <= r_lp + 2'd1;
        case (r_lp)
          2'd1:    r_w  <= dram.data_in[5:0];
          2'd2:    r_h  <= dram.data_in[5:0];
          2'd3:    r_dn <= dram.data_in[5:0];
          default: ;
        endcase
      end
      if (r_state[I_EVAL]) begin
        r_q <= r_q + 2'd1;
        if (r_q == 2'd3) begin
          r_wa <= w_waddr;
          if (w_ox_last) begin
            r_ox <= '0;
            if (w_oy_last) begin
              r_oy <= '0;
              r_d  <= r_d + 6'd1;
            end else begin
              r_oy <= r_oy + 5'd1;
            end
          end else begin
            r_ox <= r_ox + 5'd1;
          end
        end
      end
      if (r_state[I_FLUSH]) r_fl <= 1'b1;
      r_dvld <= r_state[I_EVAL];
      r_dq   <= r_q;
      if (r_dvld && r_dq == 2'd3) r_addr_out <= r_wa;
    end
  end

  pool_acc #(.DATA_WIDTH(DATA_WIDTH)) u_acc (
    .clk   (clk),
    .srst  (srst),
    .i_vld (r_dvld),
    .i_q   (r_dq),
    .i_dat (dram.data_in),
    .o_vld (w_acc_vld),
    .o_dat (w_acc_dat)
  );

  assign dram.dram_en_wr = w_acc_vld;
  assign dram.data_out   = w_acc_dat;
  assign dram.addr_out   = r_addr_out;

endmodule

// File: tb/tb_max_pool.sv
// Random-stimulus scoreboard bench for max_pool with a behavioural DRAM
// and a loop-based pooling reference model.
module tb_max_pool;
  import cnn_pkg::*;

  localparam int DW = 32;
  localparam int AW = 18;

  logic clk = 1'b0;
  logic srst;
  logic enable;
  logic done;

  max_pool_if #(.DW(DW), .AW(AW)) bus ();

  max_pool #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk    (clk),
    .srst   (srst),
    .enable (enable),
    .done   (done),
    .dram   (bus)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] mem [0:(1<<AW)-1];
  always @(posedge clk) bus.data_in <= mem[bus.addr_in];
  assign bus.dram_valid = 1'b1;

  typedef struct {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } wr_t;

  wr_t     exp_q[$];
  wr_t     e;
  int      total = 0;
  int      bad   = 0;
  int      cyc   = 0;
  int      rd_cnt = 0;
  int      wr_cnt = 0;
  int      cur_ow, cur_oh, cur_d;
  int      off, rx, ry, rd;
  logic [AW-1:0] last_wa;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input longint got, input longint exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d expected=%0d", nm, got, exp);
    end
  endtask

  // Monitor: pops the scoreboard on every write, polices read addresses.
  always @(negedge clk) begin
    if (bus.dram_en_wr) begin
      wr_cnt++;
      last_wa = bus.addr_out;
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_write addr=%0d data=%0d expected none", bus.addr_out, $signed(bus.data_out));
      end else begin
        e = exp_q.pop_front();
        if (e.a !== bus.addr_out || e.d !== bus.data_out) begin
          bad++;
          $display("FAIL write addr=%0d data=%0d expected addr=%0d data=%0d",
                   bus.addr_out, $signed(bus.data_out), e.a, $signed(e.d));
        end
      end
    end
    if (bus.dram_en_rd) begin
      rd_cnt++;
      if (int'(bus.addr_in) >= FMAP_BASE) begin
        off = int'(bus.addr_in) - FMAP_BASE;
        rx = off % 32;
        ry = (off / 32) % 32;
        rd = off / 1024;
        total++;
        if (rx >= 2 * cur_ow || ry >= 2 * cur_oh || rd >= cur_d) begin
          bad++;
          $display("FAIL read_range d=%0d y=%0d x=%0d expected inside %0dx%0dx%0d",
                   rd, ry, rx, cur_d, 2 * cur_oh, 2 * cur_ow);
        end
      end
    end else begin
      total++;
      if (bus.addr_in !== '0) begin
        bad++;
        $display("FAIL addr_in_idle got=%0d expected=0", bus.addr_in);
      end
    end
  end

  function automatic logic [AW-1:0] fm(input int d, input int y, input int x);
    return AW'(FMAP_BASE + d * 1024 + y * 32 + x);
  endfunction

  task automatic load_params(input int w, input int h, input int dn);
    mem[0] = {26'($urandom), 6'(w)};
    mem[1] = {26'($urandom), 6'(h)};
    mem[2] = {26'($urandom), 6'(dn)};
  endtask

  task automatic fill_rand(input int w, input int h, input int dn);
    for (int d = 0; d < dn; d++)
      for (int y = 0; y < h; y++)
        for (int x = 0; x < w; x++)
          mem[fm(d, y, x)] = $urandom;
  endtask

  // Reference: max of each 2x2 window, odd edges dropped, ox fastest.
  task automatic model(input int w, input int h, input int dn);
    logic [DW-1:0] m, v;
    for (int d = 0; d < dn; d++)
      for (int oy = 0; oy < h / 2; oy++)
        for (int ox = 0; ox < w / 2; ox++) begin
          m = mem[fm(d, 2 * oy, 2 * ox)];
          for (int k = 1; k < 4; k++) begin
            v = mem[fm(d, 2 * oy + k / 2, 2 * ox + k % 2)];
            if ($signed(v) > $signed(m)) m = v;
          end
          exp_q.push_back('{AW'(POOL_BASE + d * 1024 + oy * 32 + ox), m});
        end
  endtask

  task automatic run(input string nm, input int w, input int h, input int dn, input bit pulses);
    int n, c0, rd0, wr0, exp_done;
    bit seen;
    cur_ow = w / 2;
    cur_oh = h / 2;
    cur_d  = dn;
    n = cur_ow * cur_oh * dn;
    exp_done = (n == 0) ? 5 : 7 + 4 * n;
    rd0 = rd_cnt;
    wr0 = wr_cnt;
    @(posedge clk); #1;
    enable = 1'b1;
    c0 = cyc;
    @(posedge clk); #1;
    enable = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 20000 && !seen; i++) begin
      @(negedge clk);
      enable = pulses && (cyc - c0 == 100 || cyc - c0 == 9000);
      if (done) seen = 1'b1;
    end
    enable = 1'b0;
    check({nm, "_done_cycle"}, seen ? cyc - c0 : -1, exp_done);
    check({nm, "_reads"}, rd_cnt - rd0, 4 + 4 * n);
    check({nm, "_writes"}, wr_cnt - wr0, n);
    check({nm, "_pending"}, exp_q.size(), 0);
    @(negedge clk);
    check({nm, "_done_width"}, done, 0);
  endtask

  initial begin
    int c0, rd0, wr0, anydone, w, h, dn;
    srst   = 1'b1;
    enable = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_outputs",
          {bus.dram_en_rd, bus.dram_en_wr, bus.addr_in, bus.addr_out, bus.data_out, done}, 0);
    srst = 1'b0;

    // Basic 4x4 ramp with hand-derived results.
    load_params(4, 4, 1);
    for (int y = 0; y < 4; y++)
      for (int x = 0; x < 4; x++)
        mem[fm(0, y, x)] = y * 4 + x;
    exp_q.push_back('{AW'(POOL_BASE + 0),  32'd5});
    exp_q.push_back('{AW'(POOL_BASE + 1),  32'd7});
    exp_q.push_back('{AW'(POOL_BASE + 32), 32'd13});
    exp_q.push_back('{AW'(POOL_BASE + 33), 32'd15});
    run("basic", 4, 4, 1, 0);

    // Negative windows with hand-derived results.
    load_params(4, 2, 1);
    mem[fm(0, 0, 0)] = -7; mem[fm(0, 0, 1)] = -3;
    mem[fm(0, 1, 0)] = -9; mem[fm(0, 1, 1)] = -4;
    mem[fm(0, 0, 2)] = 0;  mem[fm(0, 0, 3)] = -1;
    mem[fm(0, 1, 2)] = -2; mem[fm(0, 1, 3)] = -3;
    exp_q.push_back('{AW'(POOL_BASE + 0), -32'sd3});
    exp_q.push_back('{AW'(POOL_BASE + 1), 32'd0});
    run("negative", 4, 2, 1, 0);

    // Odd dimensions: trailing column/row hold a value that would win if read.
    load_params(5, 3, 2);
    fill_rand(5, 3, 2);
    for (int d = 0; d < 2; d++) begin
      for (int y = 0; y < 3; y++) mem[fm(d, y, 4)] = 32'h7fff_ffff;
      for (int x = 0; x < 5; x++) mem[fm(d, 2, x)] = 32'h7fff_ffff;
    end
    model(5, 3, 2);
    run("odd", 5, 3, 2, 0);

    load_params(1, 4, 1);
    run("degen_w1", 1, 4, 1, 0);
    load_params(4, 4, 0);
    run("degen_d0", 4, 4, 0, 0);

    // Reset during EVAL.
    load_params(4, 4, 2);
    fill_rand(4, 4, 2);
    model(4, 4, 2);
    cur_ow = 2; cur_oh = 2; cur_d = 2;
    @(posedge clk); #1;
    enable = 1'b1;
    c0 = cyc;
    @(posedge clk); #1;
    enable = 1'b0;
    for (int i = 0; i < 50 && cyc != c0 + 10; i++) begin
      @(posedge clk); #1;
    end
    srst = 1'b1;
    @(posedge clk); #1;
    srst = 1'b0;
    @(negedge clk);
    check("rst_outputs",
          {bus.dram_en_rd, bus.dram_en_wr, bus.addr_in, bus.addr_out, bus.data_out, done}, 0);
    check("rst_first_write_seen", wr_cnt > 0, 1);
    exp_q.delete();
    rd0 = rd_cnt;
    wr0 = wr_cnt;
    anydone = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (done) anydone++;
    end
    check("rst_no_done", anydone, 0);
    check("rst_no_reads", rd_cnt - rd0, 0);
    check("rst_no_writes", wr_cnt - wr0, 0);
    model(4, 4, 2);
    run("after_rst", 4, 4, 2, 0);

    // Random small layers.
    for (int t = 0; t < 4; t++) begin
      w  = $urandom_range(2, 9);
      h  = $urandom_range(2, 9);
      dn = $urandom_range(1, 3);
      load_params(w, h, dn);
      fill_rand(w, h, dn);
      model(w, h, dn);
      run("random", w, h, dn, 0);
    end

    // Full-size layer with enable pulses while busy.
    load_params(32, 32, 16);
    fill_rand(32, 32, 16);
    model(32, 32, 16);
    run("max", 32, 32, 16, 1);
    check("max_last_addr", last_wa, POOL_BASE + 15 * 1024 + 15 * 32 + 15);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
